// File: rtl/gpio_pkg.sv
// gpio_pkg: register map shared by the GPIO port and its sub-modules.
package gpio_pkg;

  // Register offsets from the port's I/O base address.
  typedef enum logic [3:0] {
    GPIO_IN      = 4'd0,
    GPIO_OUT     = 4'd1,
    GPIO_DIR     = 4'd2,
    GPIO_SET     = 4'd3,
    GPIO_CLR     = 4'd4,
    GPIO_TGL     = 4'd5,
    GPIO_RISE_EN = 4'd6,
    GPIO_FALL_EN = 4'd7,
    GPIO_PEND    = 4'd8
  } gpio_reg_e;

  localparam int unsigned GPIO_NREGS = 9;

  // True when addr falls inside base..base+GPIO_NREGS-1. Addresses below
  // base wrap to large offsets, so a single compare covers both ends.
  function automatic logic gpio_hit(input logic [15:0] addr, input logic [15:0] base);
    logic [15:0] off;
    off = addr - base;
    return (off < 16'(GPIO_NREGS));
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: one-bit input synchroniser with optional edge detection.
// level is the last synchroniser stage; rise/fall compare it with its
// value one cycle earlier.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], din};
  end

  assign level = r_sync[SYNC_STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic r_prev;

    // Remember the previous synchronised level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_prev <= 1'b0;
      else       r_prev <= level;
    end

    assign rise = level & ~r_prev;
    assign fall = ~level & r_prev;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/gpio_port.sv
// gpio_port: parametrised GPIO port on the J1a I/O bus.
// Registers at BASE..BASE+8: IN, OUT, DIR, SET, CLR, TGL, RISE_EN,
// FALL_EN, PEND. Define GPIO_IRQ_EN to build the edge-capture interrupt
// logic (RISE_EN, FALL_EN, PEND, warm-up counter, irq); without it
// offsets +6..+8 read 0, ignore writes, and irq is 0.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter logic [15:0] BASE        = 16'd310,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      dout,
  output logic [15:0]      rdata,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // Address decode
  logic [15:0]      w_off;
  logic             w_hit;
  gpio_reg_e        w_sel;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;

  assign w_off   = mem_addr - BASE;
  assign w_hit   = gpio_hit(mem_addr, BASE);
  assign w_sel   = gpio_reg_e'(w_off[3:0]);
  assign w_wr    = io_wr & w_hit;
  assign w_wdata = dout[WIDTH-1:0];

  // Per-pin synchronisers
  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_EN     (IRQ_EN)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (pad_in[gi]),
      .level (w_level[gi]),
      .rise  (w_rise[gi]),
      .fall  (w_fall[gi])
    );
  end

  // Output value and direction registers
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;

  // OUT takes plain writes and the atomic set/clear/toggle aliases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_wr) begin
      case (w_sel)
        GPIO_OUT: r_out <= w_wdata;
        GPIO_SET: r_out <= r_out | w_wdata;
        GPIO_CLR: r_out <= r_out & ~w_wdata;
        GPIO_TGL: r_out <= r_out ^ w_wdata;
        default:  r_out <= r_out;
      endcase
    end
  end

  // DIR register: 1 drives the pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_dir <= '0;
    else if (w_wr && w_sel == GPIO_DIR) r_dir <= w_wdata;
  end

  assign pad_out = r_out;
  assign pad_oe  = r_dir;

`ifdef GPIO_IRQ_EN
  // Edge capture
  localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned WARM_W   = $clog2(WARM_MAX + 1);

  logic [WARM_W-1:0] r_warm;
  logic              w_warm_done;
  logic [WIDTH-1:0]  r_rise_en;
  logic [WIDTH-1:0]  r_fall_en;
  logic [WIDTH-1:0]  r_pend;
  logic [WIDTH-1:0]  w_capture;
  logic [WIDTH-1:0]  w_w1c;

  assign w_warm_done = (r_warm == WARM_W'(WARM_MAX));

  // Hold off capture until the synchronisers hold real pin levels, so
  // pins already high at reset do not look like rising edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_warm <= '0;
    else if (!w_warm_done) r_warm <= r_warm + WARM_W'(1);
  end

  // Edge-enable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (w_sel)
        GPIO_RISE_EN: r_rise_en <= w_wdata;
        GPIO_FALL_EN: r_fall_en <= w_wdata;
        default: begin
          r_rise_en <= r_rise_en;
          r_fall_en <= r_fall_en;
        end
      endcase
    end
  end

  // Qualified edges and write-one-to-clear mask for this cycle.
  always_comb begin
    w_capture = '0;
    w_w1c     = '0;
    if (w_warm_done) w_capture = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    if (w_wr && w_sel == GPIO_PEND) w_w1c = w_wdata;
  end

  // Pending edges; a capture in the same cycle as its W1C keeps the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pend <= '0;
    else       r_pend <= (r_pend & ~w_w1c) | w_capture;
  end

  assign irq = |r_pend;
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux; zero unless the address hits this block.
  logic [WIDTH-1:0] w_rd;

  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      case (w_sel)
        GPIO_IN:      w_rd = w_level;
        GPIO_OUT:     w_rd = r_out;
        GPIO_DIR:     w_rd = r_dir;
`ifdef GPIO_IRQ_EN
        GPIO_RISE_EN: w_rd = r_rise_en;
        GPIO_FALL_EN: w_rd = r_fall_en;
        GPIO_PEND:    w_rd = r_pend;
`endif
        default:      w_rd = '0;
      endcase
    end
  end

  assign rdata = 16'(w_rd);

  // Reads have no side effects, so the read strobe is not needed; upper
  // data bits and edge outputs go unused in narrow or non-IRQ builds.
  logic w_unused_ok;
  assign w_unused_ok = ^{1'b0, io_rd, dout, w_rise, w_fall};

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: table-driven, directed and randomized checks of gpio_port.
module tb_gpio_port;
  import gpio_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam logic [15:0] BASE  = 16'd310;
  localparam int unsigned S     = 2;

`ifdef GPIO_IRQ_EN
  localparam bit TB_IRQ = 1'b1;
`else
  localparam bit TB_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] rdata;
  logic [15:0] pad_in;
  logic [15:0] pad_out;
  logic [15:0] pad_oe;
  logic        irq;

  gpio_port #(
    .WIDTH       (WIDTH),
    .BASE        (BASE),
    .SYNC_STAGES (S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .mem_addr (mem_addr),
    .dout     (dout),
    .rdata    (rdata),
    .pad_in   (pad_in),
    .pad_out  (pad_out),
    .pad_oe   (pad_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: pin history plus register-map rules.
  logic [15:0] hist [0:4095];
  int          n_edge = 0;
  logic [15:0] m_out  = '0;
  logic [15:0] m_dir  = '0;
  logic [15:0] m_ren  = '0;
  logic [15:0] m_fen  = '0;
  logic [15:0] m_pend = '0;

  // Synchronised level visible after edge j: the pin value sampled S-1
  // edges earlier (0 before any sample since reset).
  function automatic logic [15:0] lvl(input int j);
    int k;
    k = j - int'(S) + 1;
    if (k < 1 || k > 4095) return '0;
    return hist[k];
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [15:0] cap;
    logic [15:0] w1c;
    int          off;
    if (reset) begin
      n_edge = 0;
      m_out  = '0;
      m_dir  = '0;
      m_ren  = '0;
      m_fen  = '0;
      m_pend = '0;
    end else begin
      n_edge++;
      if (n_edge <= 4095) hist[n_edge] = pad_in;
      cap = '0;
      if (n_edge - 1 >= int'(S) + 1)
        cap = (m_ren & lvl(n_edge-1) & ~lvl(n_edge-2)) |
              (m_fen & ~lvl(n_edge-1) & lvl(n_edge-2));
      w1c = '0;
      off = int'(mem_addr) - int'(BASE);
      if (io_wr) begin
        case (off)
          1: m_out = dout;
          2: m_dir = dout;
          3: m_out = m_out | dout;
          4: m_out = m_out & ~dout;
          5: m_out = m_out ^ dout;
`ifdef GPIO_IRQ_EN
          6: m_ren = dout;
          7: m_fen = dout;
          8: w1c   = dout;
`endif
          default: ;
        endcase
      end
      m_pend = (m_pend & ~w1c) | cap;
    end
  end

  function automatic logic [15:0] exp_read(input logic [15:0] addr);
    int off;
    off = int'(addr) - int'(BASE);
    case (off)
      0: return lvl(n_edge);
      1: return m_out;
      2: return m_dir;
`ifdef GPIO_IRQ_EN
      6: return m_ren;
      7: return m_fen;
      8: return m_pend;
`endif
      default: return '0;
    endcase
  endfunction

  // One write cycle; returns at the falling edge after the write edge.
  task automatic bus_write(input int off, input logic [15:0] d);
    @(negedge clk);
    io_wr    = 1'b1;
    mem_addr = BASE + 16'(off);
    dout     = d;
    @(negedge clk);
    io_wr    = 1'b0;
  endtask

  task automatic bus_read(input int off, output logic [15:0] v);
    io_rd    = 1'b1;
    mem_addr = BASE + 16'(off);
    #1;
    v        = rdata;
    io_rd    = 1'b0;
  endtask

  typedef struct {
    int          wr_off;
    logic [15:0] wr_data;
    int          rd_off;
    logic [15:0] exp_rd;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [15:0] v;
    logic [15:0] e8;
    logic [15:0] e1;

    e8 = TB_IRQ ? 16'h0008 : 16'h0000;
    e1 = TB_IRQ ? 16'h0001 : 16'h0000;

    vt[0]  = '{ 2, 16'h00FF,  2, 16'h00FF, 16'h0000, 16'h00FF};
    vt[1]  = '{ 1, 16'hA5A5,  1, 16'hA5A5, 16'hA5A5, 16'h00FF};
    vt[2]  = '{ 1, 16'h00F0,  1, 16'h00F0, 16'h00F0, 16'h00FF};
    vt[3]  = '{ 3, 16'h000F,  3, 16'h0000, 16'h00FF, 16'h00FF};
    vt[4]  = '{ 4, 16'h0011,  4, 16'h0000, 16'h00EE, 16'h00FF};
    vt[5]  = '{ 5, 16'hFFFF,  5, 16'h0000, 16'hFF11, 16'h00FF};
    vt[6]  = '{ 9, 16'hFFFF,  1, 16'hFF11, 16'hFF11, 16'h00FF};
    vt[7]  = '{-1, 16'h0000, -1, 16'h0000, 16'hFF11, 16'h00FF};
    vt[8]  = '{ 2, 16'h0000,  2, 16'h0000, 16'hFF11, 16'h0000};
    vt[9]  = '{ 6, 16'h00F0,  6, TB_IRQ ? 16'h00F0 : 16'h0000, 16'hFF11, 16'h0000};
    vt[10] = '{ 6, 16'h0000,  6, 16'h0000, 16'hFF11, 16'h0000};
    vt[11] = '{ 8, 16'hFFFF,  8, 16'h0000, 16'hFF11, 16'h0000};

    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0;
    mem_addr = BASE + 16'd1; dout = '0; pad_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_pad_out", pad_out, 16'h0000);
    check("rst_pad_oe", pad_oe, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Register map vectors
    for (int i = 0; i < 12; i++) begin
      bus_write(vt[i].wr_off, vt[i].wr_data);
      bus_read(vt[i].rd_off, v);
      check($sformatf("vec%0d_rdata", i), v, vt[i].exp_rd);
      check($sformatf("vec%0d_pad_out", i), pad_out, vt[i].exp_out);
      check($sformatf("vec%0d_pad_oe", i), pad_oe, vt[i].exp_oe);
    end

    // Input synchronisation latency
    repeat (2) @(negedge clk);
    pad_in[3] = 1'b1;
    bus_read(0, v);
    check("sync_t0", v & 16'h0008, 16'h0000);
    @(negedge clk);
    bus_read(0, v);
    check("sync_t1", v & 16'h0008, 16'h0000);
    @(negedge clk);
    bus_read(0, v);
    check("sync_t2", v & 16'h0008, 16'h0008);

    // Falling edge with FALL_EN=0 is ignored
    @(negedge clk);
    pad_in[3] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(8, v);
    check("fall_ignored", v, 16'h0000);

    // Rising edge capture timing
    bus_write(6, 16'h0008);
    pad_in[3] = 1'b1;
    @(negedge clk);
    bus_read(8, v);
    check("rise_t1_pend", v, 16'h0000);
    @(negedge clk);
    bus_read(8, v);
    check("rise_t2_pend", v, 16'h0000);
    @(negedge clk);
    bus_read(8, v);
    check("rise_t3_pend", v, e8);
    check("rise_t3_irq", {15'b0, irq}, e8 >> 3);

    pad_in[3] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(8, v);
    check("fall_keeps_pend", v, e8);

    // W1C clears
    bus_write(8, 16'h0008);
    bus_read(8, v);
    check("w1c_pend", v, 16'h0000);
    check("w1c_irq", {15'b0, irq}, 16'h0000);

    // Capture coinciding with W1C wins
    @(negedge clk);
    pad_in[3] = 1'b1;
    @(negedge clk);
    bus_write(8, 16'h0008);
    bus_read(8, v);
    check("w1c_collide_pend", v, e8);
    check("w1c_collide_irq", {15'b0, irq}, e8 >> 3);

    // Asynchronous reset mid-run
    bus_write(1, 16'h1234);
    bus_write(2, 16'h00FF);
    mem_addr = BASE + 16'd1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_pad_out", pad_out, 16'h0000);
    check("arst_pad_oe", pad_oe, 16'h0000);
    check("arst_irq", {15'b0, irq}, 16'h0000);
    check("arst_rdata", rdata, 16'h0000);

    // Warm-up: pins high through reset must not register rising edges
    pad_in = 16'hFFFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_write(6, 16'hFFFF);
    repeat (8) @(negedge clk);
    bus_read(8, v);
    check("warm_pend", v, 16'h0000);
    check("warm_irq", {15'b0, irq}, 16'h0000);
    bus_read(0, v);
    check("warm_in", v, 16'hFFFF);

    // Capture works once warm-up is over
    pad_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    pad_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(8, v);
    check("post_warm_pend", v, e1);
    bus_write(8, 16'hFFFF);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) pad_in = pad_in ^ 16'(1 << $urandom_range(15));
      io_wr    = 1'($urandom_range(1));
      io_rd    = ~io_wr;
      mem_addr = BASE + 16'($urandom_range(11)) - 16'd1;
      dout     = 16'($urandom);
      #1;
      check("rnd_pad_out", pad_out, m_out);
      check("rnd_pad_oe", pad_oe, m_dir);
      check("rnd_irq", {15'b0, irq}, {15'b0, |m_pend});
      check($sformatf("rnd_rdata_a%0d", mem_addr), rdata, exp_read(mem_addr));
    end
    io_wr = 1'b0;
    io_rd = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
